// File: rtl/sort4_unpack.sv
// Serializes one packed 4-lane block per handshake into lane-ordered words,
// flagging blocks that are not in non-decreasing unsigned order.
module sort4_unpack #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_idx,
  output logic               out_last,
  output logic               out_unsorted,
  output logic [15:0]        blk_count
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] BUSY  = 1'b1;

  logic [0:0]         state;
  logic [4*WIDTH-1:0] blk;
  logic [1:0]         idx;
  logic               unsorted;
  logic [15:0]        cnt;

  logic               busy;
  logic               out_hs;
  logic               in_hs;
  logic               in_unsorted;

  assign busy   = (state == BUSY);
  assign out_hs = busy && out_ready;

  // Reload is allowed in the same cycle the last word leaves, so blocks stream
  // without a bubble; this is the only combinational input-to-output path.
  assign in_ready = !busy || (out_hs && (idx == 2'd3));
  assign in_hs    = in_valid && in_ready;

  assign in_unsorted = (in_data[WIDTH-1:0]         > in_data[2*WIDTH-1:WIDTH])   ||
                       (in_data[2*WIDTH-1:WIDTH]   > in_data[3*WIDTH-1:2*WIDTH]) ||
                       (in_data[3*WIDTH-1:2*WIDTH] > in_data[4*WIDTH-1:3*WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      blk      <= '0;
      idx      <= '0;
      unsorted <= 1'b0;
      cnt      <= '0;
    end else begin
      if (out_hs) begin
        if (idx == 2'd3) begin
          cnt <= cnt + 16'd1;
          if (!in_hs) begin
            state <= EMPTY;
            idx   <= '0;
          end
        end else begin
          idx <= idx + 2'd1;
        end
      end
      if (in_hs) begin
        blk      <= in_data;
        unsorted <= in_unsorted;
        idx      <= '0;
        state    <= BUSY;
      end
    end
  end

  always_comb begin
    out_data = '0;
    case (idx)
      2'd0:    out_data = blk[WIDTH-1:0];
      2'd1:    out_data = blk[2*WIDTH-1:WIDTH];
      2'd2:    out_data = blk[3*WIDTH-1:2*WIDTH];
      default: out_data = blk[4*WIDTH-1:3*WIDTH];
    endcase
  end

  assign out_valid    = busy;
  assign out_idx      = idx;
  assign out_last     = busy && (idx == 2'd3);
  assign out_unsorted = busy && unsorted;
  assign blk_count    = cnt;

endmodule

// File: tb/tb_sort4_unpack.sv
// Self-checking bench for sort4_unpack: directed lane patterns plus a
// randomized backpressure run scored against a word-queue reference model.
module tb_sort4_unpack;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [4*W-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     out_idx;
  logic           out_last;
  logic           out_unsorted;
  logic [15:0]    blk_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   i;
    logic         u;
  } word_t;

  always #5 clk = ~clk;

  sort4_unpack #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_unsorted(out_unsorted),
    .blk_count(blk_count)
  );

  function automatic logic [4*W-1:0] pack(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk); #1 rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
    checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL rst_out_idx: got %0d expected 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b expected 0", out_last); end
    checks++; if (out_unsorted !== 1'b0) begin errors++; $display("FAIL rst_out_unsorted: got %0b expected 0", out_unsorted); end
    checks++; if (blk_count !== 16'd0) begin errors++; $display("FAIL rst_blk_count: got %0d expected 0", blk_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    @(posedge clk); #1 rst = 1'b0; #1;
    exp_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %0b expected 0", out_valid); end
      checks++; if (blk_count !== 16'd0) begin errors++; $display("FAIL idle_blk_count: got %0d expected 0", blk_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b expected 1", in_ready); end
    end
  endtask

  task automatic test_single_sorted();
    logic [W-1:0] exp [4];
    exp = '{32'd1, 32'd5, 32'd5, 32'd9};
    @(posedge clk); #1;
    in_data = pack(exp[0], exp[1], exp[2], exp[3]); in_valid = 1'b1; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept_ready: got %0b expected 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %0b expected 1", k, out_valid); end
      checks++; if (out_data !== exp[k]) begin errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", k, out_data, exp[k]); end
      checks++; if (out_idx !== k[1:0]) begin errors++; $display("FAIL single_idx[%0d]: got %0d expected %0d", k, out_idx, k); end
      checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL single_last[%0d]: got %0b expected %0b", k, out_last, k == 3); end
      checks++; if (out_unsorted !== 1'b0) begin errors++; $display("FAIL single_unsorted[%0d]: got %0b expected 0", k, out_unsorted); end
      checks++; if (in_ready !== (k == 3)) begin errors++; $display("FAIL single_in_ready[%0d]: got %0b expected %0b", k, in_ready, k == 3); end
      @(posedge clk); #2;
    end
    exp_cnt++;
    checks++; if (blk_count !== exp_cnt[15:0]) begin errors++; $display("FAIL single_blk_count: got %0d expected %0d", blk_count, exp_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_unsorted();
    logic [W-1:0] blocks [2][4];
    blocks = '{'{32'd3, 32'd2, 32'd7, 32'd8}, '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0}};
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      in_data = pack(blocks[b][0], blocks[b][1], blocks[b][2], blocks[b][3]); in_valid = 1'b1; #1;
      @(posedge clk); #1 in_valid = 1'b0; #1;
      for (int k = 0; k < 4; k++) begin
        checks++; if (out_data !== blocks[b][k]) begin errors++; $display("FAIL unsorted_data[%0d][%0d]: got %0h expected %0h", b, k, out_data, blocks[b][k]); end
        checks++; if (out_unsorted !== 1'b1) begin errors++; $display("FAIL unsorted_flag[%0d][%0d]: got %0b expected 1", b, k, out_unsorted); end
        @(posedge clk); #2;
      end
      exp_cnt++;
      checks++; if (blk_count !== exp_cnt[15:0]) begin errors++; $display("FAIL unsorted_blk_count[%0d]: got %0d expected %0d", b, blk_count, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    in_data = pack(32'd0, 32'd1, 32'd2, 32'd3); in_valid = 1'b1; out_ready = 1'b1; #1;
    @(posedge clk); #1 in_data = pack(32'd4, 32'd5, 32'd6, 32'd7); #1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", k, out_valid); end
      checks++; if (out_data !== 32'(k)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", k, out_data, k); end
      checks++; if (out_last !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_last[%0d]: got %0b expected %0b", k, out_last, k % 4 == 3); end
      checks++; if (in_ready !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %0b expected %0b", k, in_ready, k % 4 == 3); end
      @(posedge clk); #1;
      if (k == 3) in_valid = 1'b0;
      #1;
    end
    exp_cnt += 2;
    checks++; if (blk_count !== exp_cnt[15:0]) begin errors++; $display("FAIL b2b_blk_count: got %0d expected %0d", blk_count, exp_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    word_t        expq [$];
    word_t        w;
    logic [W-1:0] l [$];
    logic [W-1:0] cur [4];
    logic         cur_u;
    logic [W-1:0] pd;
    logic [1:0]   pi;
    logic         pl, pu, prev_stall, acc, ev, eir;
    int           sent, cyc;
    sent = 0; cyc = 0; prev_stall = 1'b0; acc = 1'b0;
    pd = '0; pi = '0; pl = 1'b0; pu = 1'b0; cur_u = 1'b0;
    while ((sent < 100 || expq.size() != 0) && cyc < 4000) begin
      @(posedge clk); #1; cyc++;
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      out_ready = 1'($urandom % 2);
      if (!in_valid && sent < 100 && ($urandom % 3) != 0) begin
        l.delete();
        for (int j = 0; j < 4; j++) l.push_back(($urandom % 2) ? W'($urandom_range(0, 3)) : W'($urandom));
        if ($urandom % 2) l.sort();
        for (int j = 0; j < 4; j++) cur[j] = l[j];
        cur_u = !(cur[0] <= cur[1] && cur[1] <= cur[2] && cur[2] <= cur[3]);
        in_data = pack(cur[0], cur[1], cur[2], cur[3]);
        in_valid = 1'b1;
      end
      #1;
      ev  = (expq.size() != 0);
      eir = !ev || (expq.size() == 1 && out_ready);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL bp_valid c%0d: got %0b expected %0b", cyc, out_valid, ev); end
      checks++; if (in_ready !== eir) begin errors++; $display("FAIL bp_in_ready c%0d: got %0b expected %0b", cyc, in_ready, eir); end
      checks++; if (blk_count !== exp_cnt[15:0]) begin errors++; $display("FAIL bp_blk_count c%0d: got %0d expected %0d", cyc, blk_count, exp_cnt[15:0]); end
      if (ev) begin
        w = expq[0];
        checks++; if (out_data !== w.d) begin errors++; $display("FAIL bp_data c%0d: got %0h expected %0h", cyc, out_data, w.d); end
        checks++; if (out_idx !== w.i) begin errors++; $display("FAIL bp_idx c%0d: got %0d expected %0d", cyc, out_idx, w.i); end
        checks++; if (out_last !== (w.i == 2'd3)) begin errors++; $display("FAIL bp_last c%0d: got %0b expected %0b", cyc, out_last, w.i == 2'd3); end
        checks++; if (out_unsorted !== w.u) begin errors++; $display("FAIL bp_unsorted c%0d: got %0b expected %0b", cyc, out_unsorted, w.u); end
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== pd || out_idx !== pi || out_last !== pl || out_unsorted !== pu) begin
          errors++; $display("FAIL bp_stall_stable c%0d: got %0h/%0d expected %0h/%0d", cyc, out_data, out_idx, pd, pi);
        end
      end
      prev_stall = ev && !out_ready;
      pd = out_data; pi = out_idx; pl = out_last; pu = out_unsorted;
      if (ev && out_ready) begin
        w = expq.pop_front();
        if (w.i == 2'd3) exp_cnt++;
      end
      if (in_valid && eir) begin
        for (int j = 0; j < 4; j++) expq.push_back('{d: cur[j], i: j[1:0], u: cur_u});
        sent++;
        acc = 1'b1;
      end
    end
    checks++; if (cyc >= 4000) begin errors++; $display("FAIL bp_timeout: got %0d blocks expected 100", sent); end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1; #1;
    checks++; if (blk_count !== exp_cnt[15:0]) begin errors++; $display("FAIL bp_final_count: got %0d expected %0d", blk_count, exp_cnt[15:0]); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_block();
    @(posedge clk); #1;
    in_data = pack(32'd10, 32'd20, 32'd30, 32'd40); in_valid = 1'b1; out_ready = 1'b1; #1;
    @(posedge clk); #1 in_valid = 1'b0; #1;
    @(posedge clk); #2;
    checks++; if (out_data !== 32'd20) begin errors++; $display("FAIL mid_lane1: got %0d expected 20", out_data); end
    @(posedge clk); #1 rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b expected 0", out_valid); end
    checks++; if (blk_count !== 16'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", blk_count); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_rst_data: got %0h expected 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %0b expected 1", in_ready); end
    exp_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    in_data = pack(32'd7, 32'd6, 32'd5, 32'd4); in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready: got %0b expected 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_post_valid: got %0b expected 1", out_valid); end
    checks++; if (out_data !== 32'd7) begin errors++; $display("FAIL mid_post_data: got %0d expected 7", out_data); end
    checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL mid_post_idx: got %0d expected 0", out_idx); end
    checks++; if (out_unsorted !== 1'b1) begin errors++; $display("FAIL mid_post_unsorted: got %0b expected 1", out_unsorted); end
    repeat (4) begin @(posedge clk); #2; end
    exp_cnt++;
    checks++; if (blk_count !== exp_cnt[15:0]) begin errors++; $display("FAIL mid_post_count: got %0d expected %0d", blk_count, exp_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_sorted();
    test_unsorted();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
